muldiv_hilo_unit: RTL and testbench



---
 rtl/muldiv_hilo_unit.sv | 207 ++++++++++++++++++++
 tb/tb_muldiv_hilo_unit.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: iterative multiply/divide unit with HI/LO result registers.
//
// MULT/MULTU/DIV/DIVU take N+1 cycles after acceptance (N iterations plus one
// sign-fix cycle). MTHI/MTLO write HI/LO directly in one cycle. Commands are
// sampled only while idle; control must stall on busy.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-high reset
//   start    - command strobe, sampled only in IDLE
//   op       - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   rs_data  - operand A / dividend / MTHI-MTLO source
//   rt_data  - operand B / divisor
//   busy     - high while a mul/div is in flight
//   done     - one-cycle pulse after HI/LO were updated by a mul/div
//   hi, lo   - HI/LO result registers
module muldiv_hilo_unit #(
    parameter int unsigned N  = 32,
    parameter int unsigned CW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] rs_data,
    input  logic [N-1:0] rt_data,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix
    } state_e;

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    // Multiply: {partial product high, multiplier shifting out}.
    // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
    logic [2*N-1:0]  acc_q, acc_d;
    logic [N-1:0]    opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic            is_div_q, is_div_d;
    logic            neg_q, neg_d;       // negate product / quotient
    logic            neg_rem_q, neg_rem_d;
    logic            div0_q, div0_d;
    logic [N-1:0]    a_raw_q, a_raw_d;   // raw dividend, returned as HI on divide by zero
    logic [N-1:0]    hi_q, hi_d;
    logic [N-1:0]    lo_q, lo_d;
    logic            done_q, done_d;

    // Iteration datapath
    logic [N:0]      mul_sum;
    logic [2*N-1:0]  mul_next;
    logic [N:0]      div_trial;
    logic [N:0]      div_diff;
    logic [2*N-1:0]  div_next;

    // Operand conditioning at accept
    logic            signed_op;
    logic            a_neg, b_neg;
    logic [N-1:0]    a_mag, b_mag;

    // Sign fix
    logic [2*N-1:0]  prod_fixed;
    logic [N-1:0]    quot_fixed, rem_fixed;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[N-1:1]};

        // Restoring step: remainder < divisor always, so the difference fits in N bits.
        // A zero divisor never borrows, giving an all-ones quotient.
        div_trial = {acc_q[2*N-1:N], acc_q[N-1]};
        div_diff  = div_trial - {1'b0, opnd_q};
        if (!div_diff[N]) begin
            div_next = {div_diff[N-1:0], acc_q[N-2:0], 1'b1};
        end else begin
            div_next = {div_trial[N-1:0], acc_q[N-2:0], 1'b0};
        end
    end

    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & rs_data[N-1];
        b_neg     = signed_op & rt_data[N-1];
        // -(-2^(N-1)) wraps to 2^(N-1), which is the correct unsigned magnitude.
        a_mag     = a_neg ? (~rs_data + 1'b1) : rs_data;
        b_mag     = b_neg ? (~rt_data + 1'b1) : rt_data;
    end

    always_comb begin
        prod_fixed = neg_q ? (~acc_q + 1'b1) : acc_q;
        quot_fixed = neg_q ? (~acc_q[N-1:0] + 1'b1) : acc_q[N-1:0];
        rem_fixed  = neg_rem_q ? (~acc_q[2*N-1:N] + 1'b1) : acc_q[2*N-1:N];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        a_raw_d   = a_raw_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    case (op)
                        OpMult, OpMultu, OpDiv, OpDivu: begin
                            is_div_d  = op[1];
                            neg_d     = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            div0_d    = op[1] & (rt_data == '0);
                            a_raw_d   = rs_data;
                            cnt_d     = '0;
                            if (op[1]) begin
                                acc_d  = {{N{1'b0}}, a_mag};
                                opnd_d = b_mag;
                            end else begin
                                acc_d  = {{N{1'b0}}, b_mag};
                                opnd_d = a_mag;
                            end
                            state_d = StRun;
                        end
                        OpMthi:  hi_d = rs_data;
                        OpMtlo:  lo_d = rs_data;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (!is_div_q) begin
                    hi_d = prod_fixed[2*N-1:N];
                    lo_d = prod_fixed[N-1:0];
                end else if (div0_q) begin
                    hi_d = a_raw_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fixed;
                    lo_d = quot_fixed;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            a_raw_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            a_raw_q   <= a_raw_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit. Inputs change and outputs are
// sampled on the falling edge. Expected {hi,lo} pairs are queued when a
// mul/div is issued and compared by a monitor on each done pulse.
module tb_muldiv_hilo_unit;

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;
    logic [63:0] exp_q[$];

    muldiv_hilo_unit #(.N(32), .CW(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    // Reference model: returns {hi, lo}.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb;
        int          qa, qb;
        logic [63:0] p;
        p = '0;
        case (o)
            OpMult: begin
                sa = $signed(a);
                sb = $signed(b);
                p  = sa * sb;
            end
            OpMultu: p = {32'h0, a} * {32'h0, b};
            OpDiv: begin
                if (b == 32'h0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    p = {32'h0, 32'h8000_0000};
                end else begin
                    qa = $signed(a);
                    qb = $signed(b);
                    p  = {32'(qa % qb), 32'(qa / qb)};
                end
            end
            OpDivu: begin
                if (b == 32'h0) p = {a, 32'hFFFF_FFFF};
                else            p = {a % b, a / b};
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: got hi=%h lo=%h, no result expected", hi, lo);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({hi, lo} !== e) begin
                    errors++;
                    $display("FAIL result: got hi=%h lo=%h, expected hi=%h lo=%h",
                             hi, lo, e[63:32], e[31:0]);
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_result);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        if (expect_result) exp_q.push_back(model(o, a, b));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy cycles until done is seen; returns at the done falling edge.
    task automatic wait_done(output int nbusy, output bit timed_out);
        nbusy     = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        start   = 1'b0;
        op      = 3'b111;
        rs_data = '0;
        rt_data = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: busy=%b done=%b, expected 0 0", busy, done);
        end
        checks++;
        if ({hi, lo} !== 64'h0) begin
            errors++;
            $display("FAIL reset_hilo: hi=%h lo=%h, expected 0 0", hi, lo);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int nb;
        bit to;
        issue(OpMult, 32'hFFFF_FFFD, 32'd5, 1'b1);
        wait_done(nb, to);
        checks++;
        if (to || nb != 33) begin
            errors++;
            $display("FAIL mult_busy: busy cycles=%0d timeout=%0d, expected 33 0", nb, to);
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL mult_done_pulse: busy=%b done=%b, expected 0 0", busy, done);
        end
        issue(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done(nb, to);
        @(negedge clk);
        issue(OpMult, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done(nb, to);
        @(negedge clk);
        issue(OpMult, 32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done(nb, to);
        @(negedge clk);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL mult_timeout: timeout=%0d, expected 0", to);
        end
    endtask

    task automatic test_div();
        int nb;
        bit to;
        logic [31:0] ops[5][2] = '{'{32'hFFFF_FFF9, 32'd2}, '{32'd7, 32'd0},
                                   '{32'h8000_0000, 32'hFFFF_FFFF}, '{32'd7, 32'hFFFF_FFFE},
                                   '{32'hFFFF_FFF9, 32'd0}};
        logic [2:0]  dop[5] = '{OpDiv, OpDivu, OpDiv, OpDiv, OpDiv};
        for (int i = 0; i < 5; i++) begin
            issue(dop[i], ops[i][0], ops[i][1], 1'b1);
            wait_done(nb, to);
            checks++;
            if (to || nb != 33) begin
                errors++;
                $display("FAIL div_busy[%0d]: busy cycles=%0d timeout=%0d, expected 33 0",
                         i, nb, to);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mthi_mtlo();
        int d0;
        int nb;
        bit to;
        d0      = done_cnt;
        start   = 1'b1;
        op      = OpMthi;
        rs_data = 32'h1234;
        @(negedge clk);
        checks++;
        if (hi !== 32'h1234 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi: hi=%h busy=%b, expected 00001234 0", hi, busy);
        end
        op      = OpMtlo;
        rs_data = 32'hABCD;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({hi, lo} !== {32'h1234, 32'hABCD}) begin
            errors++;
            $display("FAIL mtlo: hi=%h lo=%h, expected 00001234 0000abcd", hi, lo);
        end
        @(negedge clk);
        checks++;
        if (done_cnt != d0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mt_no_done: done pulses=%0d, expected %0d", done_cnt, d0);
        end
        // MTLO during a divide must be dropped.
        issue(OpDivu, 32'd100, 32'd7, 1'b1);
        repeat (3) @(negedge clk);
        start   = 1'b1;
        op      = OpMtlo;
        rs_data = 32'hDEAD;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({hi, lo} !== {32'h1234, 32'hABCD}) begin
            errors++;
            $display("FAIL mtlo_busy: hi=%h lo=%h, expected 00001234 0000abcd", hi, lo);
        end
        wait_done(nb, to);
        @(negedge clk);
        checks++;
        if (to || done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL mtlo_busy_done: pulses=%0d timeout=%0d, expected %0d 0",
                     done_cnt - d0, to, 1);
        end
    endtask

    task automatic test_abort();
        int nb;
        bit to;
        issue(OpMult, 32'd6, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre_busy: busy=%b, expected 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, hi, lo} !== 66'h0) begin
            errors++;
            $display("FAIL abort: busy=%b done=%b hi=%h lo=%h, expected all 0",
                     busy, done, hi, lo);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(OpMult, 32'd6, 32'd7, 1'b1);
        wait_done(nb, to);
        @(negedge clk);
        checks++;
        if (to || lo !== 32'd42) begin
            errors++;
            $display("FAIL abort_rerun: lo=%0d timeout=%0d, expected 42 0", lo, to);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        int nb;
        bit to;
        d0      = done_cnt;
        start   = 1'b1;
        op      = OpDivu;
        rs_data = 32'd100;
        rt_data = 32'd7;
        exp_q.push_back(model(OpDivu, 32'd100, 32'd7));
        @(negedge clk);
        wait_done(nb, to);
        checks++;
        if (to || nb != 33) begin
            errors++;
            $display("FAIL b2b_busy: busy cycles=%0d timeout=%0d, expected 33 0", nb, to);
        end
        // start still high: the next edge is idle, so the command is re-accepted there.
        exp_q.push_back(model(OpDivu, 32'd100, 32'd7));
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL b2b_reaccept: busy=%b done=%b pulses=%0d, expected 1 0 1",
                     busy, done, done_cnt - d0);
        end
        wait_done(nb, to);
        @(negedge clk);
        checks++;
        if (to || done !== 1'b0 || done_cnt != d0 + 2) begin
            errors++;
            $display("FAIL b2b_second: pulses=%0d timeout=%0d, expected 2 0",
                     done_cnt - d0, to);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_abort();
        test_back_to_back();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, expected 0",
                     exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
